// File: rtl/cc_pkg.sv
// Shared definitions for the cache-miss refill path: FSM states, address-field
// widths and the {valid, tag} entry written into the tag SRAM.
package cc_pkg;

    localparam int LINE_BEATS = 8;
    localparam int TAG_W      = 17;
    localparam int INDEX_W    = 9;
    localparam int OFFSET_W   = 6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        WRITE
    } cc_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } cc_tag_entry_t;

endpackage

// File: rtl/cc_line_buffer.sv
// Refill staging buffer: one beat written per cycle into a slot, whole line
// visible at once for the data SRAM write.
module cc_line_buffer #(
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(LINE_BEATS)-1:0] wr_slot,
    input  logic [BEAT_W-1:0]            wr_data,
    output logic [LINE_BEATS*BEAT_W-1:0] line
);

    logic [LINE_BEATS-1:0][BEAT_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (!rst_n)
            mem <= '0;
        else if (wr_en)
            mem[wr_slot] <= wr_data;
    end

    assign line = mem;

endmodule

// File: rtl/cc_miss_handler.sv
// Cache miss handler: latches a missing address, issues one line read, packs
// the returned beats, forwards the critical beat and writes tag + data SRAMs.
module cc_miss_handler
    import cc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = cc_pkg::LINE_BEATS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hit_i,
    input  logic                         miss_i,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic [INDEX_W-1:0]           index_i,
    input  logic [OFFSET_W-1:0]          offset_i,
    output logic                         busy_o,
    output logic                         mem_arvalid_o,
    input  logic                         mem_arready_i,
    output logic [ADDR_W-1:0]            mem_araddr_o,
    input  logic                         mem_rvalid_i,
    output logic                         mem_rready_o,
    input  logic [BEAT_W-1:0]            mem_rdata_i,
    input  logic                         mem_rlast_i,
    output logic                         tag_wren_o,
    output logic [INDEX_W-1:0]           tag_windex_o,
    output logic [TAG_W:0]               tag_wdata_o,
    output logic                         data_wren_o,
    output logic [INDEX_W-1:0]           data_windex_o,
    output logic [LINE_BEATS*BEAT_W-1:0] data_wdata_o,
    output logic                         fwd_valid_o,
    output logic [BEAT_W-1:0]            fwd_data_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int CNT_W = $clog2(LINE_BEATS);

    cc_state_e                   state;
    logic [TAG_W-1:0]            tag_q;
    logic [INDEX_W-1:0]          index_q;
    logic [CNT_W-1:0]            crit_q;
    logic [CNT_W-1:0]            beat_cnt;
    logic                        arvalid_q;
    logic [ADDR_W-1:0]           araddr_q;
    logic                        rready_q;
    logic                        wr_q;
    logic                        fwd_valid_q;
    logic [BEAT_W-1:0]           fwd_data_q;
    logic                        err_q;
    logic                        beat_acc;
    logic                        last_beat;
    logic [LINE_BEATS*BEAT_W-1:0] line;
    cc_tag_entry_t               entry;

    // A hit needs no action, and the byte-within-beat offset does not affect the refill.
    logic unused_in;
    assign unused_in = ^{hit_i, offset_i[OFFSET_W-CNT_W-1:0]};

    assign beat_acc  = rready_q && mem_rvalid_i;
    assign last_beat = (beat_cnt == CNT_W'(LINE_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tag_q       <= '0;
            index_q     <= '0;
            crit_q      <= '0;
            beat_cnt    <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            wr_q        <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_q        <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            err_q       <= 1'b0;
            case (state)
                IDLE: if (miss_i) begin
                    tag_q     <= tag_i;
                    index_q   <= index_i;
                    crit_q    <= offset_i[OFFSET_W-1:OFFSET_W-CNT_W];
                    araddr_q  <= ADDR_W'({tag_i, index_i, {OFFSET_W{1'b0}}});
                    arvalid_q <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (mem_arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    beat_cnt  <= '0;
                    state     <= FILL;
                end
                FILL: if (beat_acc) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == crit_q) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= mem_rdata_i;
                    end
                    // Beat count alone ends the fill; rlast is only cross-checked.
                    err_q <= (mem_rlast_i != last_beat);
                    if (last_beat) begin
                        rready_q <= 1'b0;
                        wr_q     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    cc_line_buffer #(
        .BEAT_W     (BEAT_W),
        .LINE_BEATS (LINE_BEATS)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (beat_acc),
        .wr_slot (beat_cnt),
        .wr_data (mem_rdata_i),
        .line    (line)
    );

    assign entry = '{valid: 1'b1, tag: tag_q};

    assign busy_o        = (state != IDLE);
    assign mem_arvalid_o = arvalid_q;
    assign mem_araddr_o  = araddr_q;
    assign mem_rready_o  = rready_q;
    assign tag_wren_o    = wr_q;
    assign data_wren_o   = wr_q;
    assign done_o        = wr_q;
    assign tag_windex_o  = wr_q ? index_q : '0;
    assign data_windex_o = wr_q ? index_q : '0;
    assign tag_wdata_o   = wr_q ? entry : '0;
    assign data_wdata_o  = wr_q ? line : '0;
    assign fwd_valid_o   = fwd_valid_q;
    assign fwd_data_o    = fwd_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cc_miss_handler.sv
// Scoreboard bench for cc_miss_handler: drivers push expected AR / forward /
// SRAM-write events, an independent monitor pops and compares them.
module tb_cc_miss_handler;

    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int LB     = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               hit_i = 1'b0, miss_i = 1'b0;
    logic [16:0]        tag_i = '0;
    logic [8:0]         index_i = '0;
    logic [5:0]         offset_i = '0;
    logic               busy_o, mem_arvalid_o, mem_arready_i = 1'b0;
    logic [ADDR_W-1:0]  mem_araddr_o;
    logic               mem_rvalid_i = 1'b0, mem_rready_o;
    logic [BEAT_W-1:0]  mem_rdata_i = '0;
    logic               mem_rlast_i = 1'b0;
    logic               tag_wren_o, data_wren_o, fwd_valid_o, done_o, err_o;
    logic [8:0]         tag_windex_o, data_windex_o;
    logic [17:0]        tag_wdata_o;
    logic [LB*BEAT_W-1:0] data_wdata_o;
    logic [BEAT_W-1:0]  fwd_data_o;

    cc_miss_handler #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_BEATS(LB)) dut (
        .clk(clk), .rst_n(rst_n), .hit_i(hit_i), .miss_i(miss_i),
        .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i), .busy_o(busy_o),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
        .mem_araddr_o(mem_araddr_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rready_o(mem_rready_o), .mem_rdata_i(mem_rdata_i),
        .mem_rlast_i(mem_rlast_i), .tag_wren_o(tag_wren_o),
        .tag_windex_o(tag_windex_o), .tag_wdata_o(tag_wdata_o),
        .data_wren_o(data_wren_o), .data_windex_o(data_windex_o),
        .data_wdata_o(data_wdata_o), .fwd_valid_o(fwd_valid_o),
        .fwd_data_o(fwd_data_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [17:0]  tw;
        logic [8:0]   idx;
        logic [511:0] line;
    } wr_t;

    logic [31:0] q_ar[$];
    logic [63:0] q_fwd[$];
    wr_t         q_wr[$];

    // Monitor: compares every DUT-presented event against the scoreboard.
    logic        ar_hold = 1'b0;
    logic [31:0] ar_prev = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ar_hold = 1'b0;
        end else begin
            if (mem_arvalid_o) begin
                if (ar_hold) chk("araddr_stable", mem_araddr_o, ar_prev);
                chk("rready_during_req", mem_rready_o, 1'b0);
                if (mem_arready_i) begin
                    if (q_ar.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
                    else chk("araddr", mem_araddr_o, q_ar.pop_front());
                    ar_hold = 1'b0;
                end else begin
                    ar_hold = 1'b1;
                    ar_prev = mem_araddr_o;
                end
            end else begin
                ar_hold = 1'b0;
            end
            if (fwd_valid_o) begin
                if (q_fwd.size() == 0) chk("fwd_unexpected", 1'b1, 1'b0);
                else chk("fwd_data", fwd_data_o, q_fwd.pop_front());
            end
            if (tag_wren_o || data_wren_o || done_o) begin
                chk("wren_done", {tag_wren_o, data_wren_o, done_o}, 3'b111);
                if (q_wr.size() == 0) chk("write_unexpected", 1'b1, 1'b0);
                else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    chk("tag_wdata", tag_wdata_o, w.tw);
                    chk("windex", {tag_windex_o, data_windex_o}, {w.idx, w.idx});
                    chk("data_wdata", data_wdata_o, w.line);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        logic any;
        any = busy_o | mem_arvalid_o | (|mem_araddr_o) | mem_rready_o | tag_wren_o |
              (|tag_windex_o) | (|tag_wdata_o) | data_wren_o | (|data_windex_o) |
              (|data_wdata_o) | fwd_valid_o | (|fwd_data_o) | done_o | err_o;
        chk(name, any, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One refill. last_at<0: rlast on the 8th beat; else rlast only on beat last_at.
    // rst_at>=0: reset asserted while that beat is on the bus.
    task automatic refill(input logic [16:0] tg, input logic [8:0] ix, input logic [5:0] of,
                          input int ar_dly, input int gap, input int last_at, input bit both,
                          input bit extra, input int rst_at, input bit seq);
        logic [63:0]  b[8];
        logic         rl[8];
        logic [511:0] line;
        int           crit;
        int           n;
        wr_t          w;
        crit = int'(of) / 8;
        for (int k = 0; k < 8; k++) begin
            b[k]  = seq ? 64'(k) : {$urandom, $urandom};
            rl[k] = (last_at < 0) ? (k == 7) : (k == last_at);
            line[k*64 +: 64] = b[k];
        end
        q_ar.push_back(32'(tg) * 32768 + 32'(ix) * 64);
        if (rst_at < 0 || crit < rst_at) q_fwd.push_back(b[crit]);
        if (rst_at < 0) begin
            w.tw = 18'h20000 + 18'(tg); w.idx = ix; w.line = line;
            q_wr.push_back(w);
        end

        miss_i = 1'b1; hit_i = both; tag_i = tg; index_i = ix; offset_i = of;
        step();
        miss_i = 1'b0; hit_i = 1'b0; tag_i = 17'($urandom); index_i = 9'($urandom);
        chk("miss_to_arvalid", mem_arvalid_o, 1'b1);
        mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom};  // must not be taken before AR
        repeat (ar_dly) step();
        mem_arready_i = 1'b1;
        step();
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0;

        for (int k = 0; k < 8; k++) begin
            repeat (gap) step();
            n = 0;
            while (!mem_rready_o && n < 20) begin step(); n++; end
            chk("rready_fill", mem_rready_o, 1'b1);
            mem_rvalid_i = 1'b1; mem_rdata_i = b[k]; mem_rlast_i = rl[k];
            if (k == rst_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check_zero("zero_after_mid_reset");
                repeat (3) begin
                    step();
                    chk("rready_after_reset", {mem_rready_o, busy_o}, 2'b00);
                end
                mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
                return;
            end
            if (extra && k == 4) begin
                miss_i = 1'b1; tag_i = 17'($urandom); index_i = 9'($urandom);
            end
            step();
            mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; miss_i = 1'b0;
            chk("fwd_timing", fwd_valid_o, k == crit);
            chk("err", err_o, rl[k] != (k == 7));
            if (k == 7) begin
                chk("write_timing", tag_wren_o, 1'b1);
                chk("busy_in_write", busy_o, 1'b1);
                if (extra) begin
                    miss_i = 1'b1; tag_i = 17'($urandom); index_i = 9'($urandom);
                end
            end
        end
        step();
        miss_i = 1'b0;
        chk("idle_after_write", {busy_o, mem_arvalid_o}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("zero_in_reset");
        rst_n = 1'b1;
        step();
        check_zero("zero_after_reset");

        hit_i = 1'b1; tag_i = 17'h12345; index_i = 9'h1;
        step();
        hit_i = 1'b0;
        step();
        chk("hit_no_action", {busy_o, mem_arvalid_o}, 2'b00);

        refill(17'h1ABCD, 9'h055, 6'h18, 0, 0, -1, 1'b0, 1'b0, -1, 1'b1);
        refill(17'($urandom), 9'($urandom), 6'($urandom), 5, 0, -1, 1'b0, 1'b0, -1, 1'b0);
        refill(17'($urandom), 9'($urandom), 6'($urandom), 0, 2, -1, 1'b0, 1'b0, -1, 1'b0);
        refill(17'($urandom), 9'($urandom), 6'($urandom), 1, 0, 5, 1'b0, 1'b0, -1, 1'b0);
        refill(17'($urandom), 9'($urandom), 6'($urandom), 0, 1, -1, 1'b0, 1'b1, -1, 1'b0);
        refill(17'($urandom), 9'($urandom), 6'($urandom), 2, 0, -1, 1'b1, 1'b0, -1, 1'b0);
        refill(17'($urandom), 9'($urandom), 6'h00, 0, 0, -1, 1'b0, 1'b0, 3, 1'b0);
        refill(17'($urandom), 9'($urandom), 6'($urandom), 0, 0, -1, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 6; i++)
            refill(17'($urandom), 9'($urandom), 6'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), -1, 1'($urandom), 1'($urandom), -1, 1'b0);

        repeat (4) step();
        chk("scoreboard_drained", q_ar.size() + q_fwd.size() + q_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
